// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - OFDM symbol geometry constants and the CP-removal state type
package ofdm_pkg;

  localparam logic [1:0] STD_80211 = 2'b00;
  localparam logic [1:0] STD_80216 = 2'b01;
  localparam logic [1:0] STD_80222 = 2'b10;
  localparam logic [1:0] STD_RSVD  = 2'b11;

  localparam int NFFT_80211 = 64;
  localparam int CP_80211   = 16;
  localparam int NFFT_80216 = 256;
  localparam int CP_80216   = 32;
  localparam int NFFT_80222 = 2048;
  localparam int CP_80222   = 512;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CP   = 2'b01,
    DATA = 2'b10
  } state_t;

endpackage

// File: rtl/cp_geom.sv
// rtl/cp_geom.sv - decodes a standard select into NFFT-1, CP-1 and symbol-length-1
module cp_geom
  import ofdm_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic [1:0]    i_std,
  output logic [CW-1:0] o_nfft_m1,
  output logic [CW-1:0] o_cp_m1,
  output logic [CW-1:0] o_sym_m1
);

  // The reserved code decodes like 802.11; the caller never leaves IDLE for it.
  always_comb begin
    o_nfft_m1 = CW'(NFFT_80211 - 1);
    o_cp_m1   = CW'(CP_80211 - 1);
    o_sym_m1  = CW'(NFFT_80211 + CP_80211 - 1);
    case (i_std)
      STD_80216: begin
        o_nfft_m1 = CW'(NFFT_80216 - 1);
        o_cp_m1   = CW'(CP_80216 - 1);
        o_sym_m1  = CW'(NFFT_80216 + CP_80216 - 1);
      end
      STD_80222: begin
        o_nfft_m1 = CW'(NFFT_80222 - 1);
        o_cp_m1   = CW'(CP_80222 - 1);
        o_sym_m1  = CW'(NFFT_80222 + CP_80222 - 1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cp_remove.sv
// rtl/cp_remove.sv - strips the cyclic prefix from each received OFDM symbol
module cp_remove
  import ofdm_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 12
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I,
  output logic          FIRST_O,
  output logic          LAST_O,
  input  logic [1:0]    STD
);

  logic          r_cyc_d;
  logic [1:0]    r_std_q;
  state_t        r_state;
  logic [CW-1:0] r_s_cnt;

  logic [CW-1:0] w_nfft_m1;
  logic [CW-1:0] w_cp_m1;
  logic [CW-1:0] w_sym_m1;
  logic [CW-1:0] w_cp;
  logic          w_cyc_rise;
  logic          w_ena;
  logic          w_out_halt;
  logic          w_take_data;

  cp_geom #(.CW(CW)) u_geom (
    .i_std     (r_std_q),
    .o_nfft_m1 (w_nfft_m1),
    .o_cp_m1   (w_cp_m1),
    .o_sym_m1  (w_sym_m1)
  );

  // Counter index of the first useful sample: (NFFT+CP-1) - (NFFT-1).
  assign w_cp        = w_sym_m1 - w_nfft_m1;
  assign w_cyc_rise  = CYC_I & ~r_cyc_d;
  assign w_ena       = CYC_I & STB_I & WE_I;
  assign w_out_halt  = STB_O & ~ACK_I;
  assign ACK_O       = w_ena & ~w_out_halt & (r_state != IDLE);
  assign w_take_data = ACK_O & (r_state == DATA);
  assign WE_O        = STB_O;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_cyc_d <= 1'b0;
      r_std_q <= STD_80211;
      r_state <= IDLE;
      r_s_cnt <= '0;
    end else begin
      r_cyc_d <= CYC_I;
      if (w_cyc_rise) begin
        r_std_q <= STD;
      end

      if (w_cyc_rise) begin
        r_s_cnt <= '0;
      end else if (ACK_O) begin
        r_s_cnt <= (r_s_cnt == w_sym_m1) ? '0 : r_s_cnt + CW'(1);
      end

      if (!CYC_I) begin
        r_state <= IDLE;
      end else if (w_cyc_rise) begin
        r_state <= (STD != STD_RSVD) ? CP : IDLE;
      end else if (ACK_O) begin
        case (r_state)
          CP:      if (r_s_cnt == w_cp_m1)  r_state <= DATA;
          DATA:    if (r_s_cnt == w_sym_m1) r_state <= CP;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      DAT_O   <= '0;
      STB_O   <= 1'b0;
      FIRST_O <= 1'b0;
      LAST_O  <= 1'b0;
      CYC_O   <= 1'b0;
    end else begin
      if (!w_out_halt) begin
        STB_O   <= w_take_data;
        DAT_O   <= DAT_I;
        FIRST_O <= (r_s_cnt == w_cp);
        LAST_O  <= (r_s_cnt == w_sym_m1);
      end

      // The frame stays open downstream until the last registered word is taken.
      if (!CYC_I && (!STB_O || ACK_I)) begin
        CYC_O <= 1'b0;
      end else if (!w_out_halt && w_take_data) begin
        CYC_O <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cp_remove.sv
// tb/tb_cp_remove.sv - scoreboard bench for cp_remove with a randomized stimulus
module tb_cp_remove;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [31:0] DAT_I;
  logic        CYC_I, STB_I, WE_I, ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O, STB_O, WE_O, ACK_I, FIRST_O, LAST_O;
  logic [1:0]  STD;

  cp_remove dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I), .FIRST_O(FIRST_O), .LAST_O(LAST_O), .STD(STD)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic [31:0] d;
    logic        f;
    logic        l;
  } exp_t;

  exp_t        q[$];
  int          pop_cyc[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [1:0]  cur_std;
  int          acc_first_cyc;
  logic [31:0] last_useful;

  always @(posedge CLK_I) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void geom(input logic [1:0] s, output int n, output int c);
    case (s)
      2'b00:   begin n = 64;   c = 16;  end
      2'b01:   begin n = 256;  c = 32;  end
      default: begin n = 2048; c = 512; end
    endcase
  endfunction

  always @(negedge CLK_I) begin
    if (!RST_I && STB_O && ACK_I) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out: got data %0d expected no output", DAT_O);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_dat", DAT_O, e.d);
        chk("out_first", FIRST_O, e.f);
        chk("out_last", LAST_O, e.l);
        chk("out_cyc", CYC_O, 1);
        chk("out_we", WE_O, 1);
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic start_frame(input logic [1:0] s);
    STD     = s;
    cur_std = s;
    CYC_I   = 1'b1;
    STB_I   = 1'b0;
  endtask

  task automatic drive_samples(input int nsamp, input int stb_pct, input int ack_pct,
                               input int halt_at, input bit seq, output int used);
    int n, c, idx, pos;
    bit halted;
    geom(cur_std, n, c);
    idx = 0;
    used = 0;
    halted = 0;
    while (idx < nsamp && used < nsamp * 20 + 100) begin
      if (idx == halt_at && !halted) begin
        halted = 1;
        for (int k = 0; k < 5; k++) begin
          ACK_I = 1'b0;
          STB_I = 1'b1;
          DAT_I = $urandom;
          @(negedge CLK_I);
          chk("halt_ack", ACK_O, 0);
          chk("halt_dat", DAT_O, last_useful);
          chk("halt_stb", STB_O, 1);
          @(posedge CLK_I);
          #1;
        end
      end
      if (used > 0) STD = 2'($urandom);
      STB_I = int'($urandom_range(99, 0)) < stb_pct;
      ACK_I = int'($urandom_range(99, 0)) < ack_pct;
      DAT_I = seq ? 32'(idx) : $urandom;
      @(negedge CLK_I);
      used++;
      if (STB_I && ACK_O) begin
        pos = idx % (n + c);
        if (pos >= c) begin
          q.push_back('{DAT_I, pos == c, pos == n + c - 1});
          last_useful = DAT_I;
        end
        if (idx == c) acc_first_cyc = cyc;
        idx++;
      end
      @(posedge CLK_I);
      #1;
    end
    if (idx < nsamp) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got %0d accepted expected %0d", idx, nsamp);
    end
  endtask

  task automatic end_frame();
    bit done;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    ACK_I = 1'b1;
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge CLK_I);
      if (q.size() == 0 && !STB_O) done = 1;
      @(posedge CLK_I);
      #1;
    end
    chk("drain_done", done, 1);
    chk("drain_cyc_o", CYC_O, 0);
  endtask

  initial begin
    int used, n0;
    RST_I = 1'b1;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b1;
    ACK_I = 1'b1;
    STD   = 2'b00;
    DAT_I = '0;
    cur_std = 2'b00;
    acc_first_cyc = 0;
    last_useful = '0;
    repeat (2) @(posedge CLK_I);
    @(negedge CLK_I);
    chk("rst_stb", STB_O, 0);
    chk("rst_cyc", CYC_O, 0);
    chk("rst_dat", DAT_O, 0);
    chk("rst_first", FIRST_O, 0);
    chk("rst_last", LAST_O, 0);
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    @(posedge CLK_I);
    #1;

    // 802.11 single symbol, full rate
    n0 = pop_cyc.size();
    start_frame(2'b00);
    drive_samples(80, 100, 100, -1, 1, used);
    end_frame();
    chk("t1_cycles", used, 81);
    chk("t1_count", pop_cyc.size() - n0, 64);
    if (pop_cyc.size() > n0) chk("t1_latency", pop_cyc[n0] - acc_first_cyc, 1);
    else chk("t1_latency", -1, 1);

    // 802.16, three back-to-back symbols
    n0 = pop_cyc.size();
    start_frame(2'b01);
    drive_samples(864, 100, 100, -1, 1, used);
    end_frame();
    chk("t2_count", pop_cyc.size() - n0, 768);
    if (pop_cyc.size() >= n0 + 768) chk("t2_span", pop_cyc[n0 + 767] - pop_cyc[n0], 831);
    else chk("t2_span", -1, 831);

    // downstream stall mid-DATA
    n0 = pop_cyc.size();
    start_frame(2'b00);
    drive_samples(80, 100, 100, 40, 1, used);
    end_frame();
    chk("t3_count", pop_cyc.size() - n0, 64);

    // 802.22 truncated frame, last word held by downstream
    n0 = pop_cyc.size();
    start_frame(2'b10);
    drive_samples(600, 100, 100, -1, 1, used);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    ACK_I = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK_I);
      chk("t4_cyc_hold", CYC_O, 1);
      chk("t4_stb_hold", STB_O, 1);
      chk("t4_no_last", LAST_O, 0);
      @(posedge CLK_I);
      #1;
    end
    end_frame();
    chk("t4_count", pop_cyc.size() - n0, 88);
    n0 = pop_cyc.size();
    start_frame(2'b00);
    drive_samples(80, 100, 100, -1, 1, used);
    end_frame();
    chk("t4_next_count", pop_cyc.size() - n0, 64);

    // reserved standard
    start_frame(2'b11);
    for (int k = 0; k < 20; k++) begin
      STB_I = 1'b1;
      DAT_I = $urandom;
      @(negedge CLK_I);
      chk("rsvd_ack", ACK_O, 0);
      chk("rsvd_stb", STB_O, 0);
      chk("rsvd_cyc", CYC_O, 0);
      @(posedge CLK_I);
      #1;
    end
    end_frame();

    // asynchronous reset mid-DATA
    start_frame(2'b00);
    drive_samples(30, 100, 100, -1, 1, used);
    chk("pre_rst_stb", STB_O, 1);
    #2;
    RST_I = 1'b1;
    #1;
    chk("arst_stb", STB_O, 0);
    chk("arst_cyc", CYC_O, 0);
    chk("arst_dat", DAT_O, 0);
    chk("arst_first", FIRST_O, 0);
    chk("arst_last", LAST_O, 0);
    chk("arst_ack", ACK_O, 0);
    q.delete();
    CYC_I = 1'b0;
    STB_I = 1'b0;
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    @(posedge CLK_I);
    #1;
    n0 = pop_cyc.size();
    start_frame(2'b00);
    drive_samples(80, 100, 100, -1, 1, used);
    end_frame();
    chk("post_rst_count", pop_cyc.size() - n0, 64);

    // randomized frames with input gaps and downstream back-pressure
    for (int f = 0; f < 5; f++) begin
      start_frame(2'($urandom_range(2, 0)));
      drive_samples(int'($urandom_range(700, 20)), int'($urandom_range(100, 60)),
                    int'($urandom_range(100, 50)), -1, 0, used);
      end_frame();
    end

    chk("final_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
